tiny_alu_arbiter: RTL and testbench

Shares one tiny ALU (ops no_op=000, add=001, and=010, xor=011, mul=100; start/done handshake) between two requesters.
- Arbitrates round-robin, drives the ALU start/op/A/B and holds them until done.
- Captures the result and returns it tagged with the requester ID.
- Sits between two command sources and a single ALU instance; owns all ALU control.

---
 rtl/tiny_alu_arbiter.sv | 143 ++++++++++++++
 tb/tb_tiny_alu_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_alu_arbiter.sv
// tiny_alu_arbiter: shares one small ALU between two requesters.
// Round-robin grant, registered ALU issue held until alu_done (or timeout),
// and a one-cycle tagged response pulse.
//
// Handshake: a command transfers on a rising edge where reqN_valid and
// reqN_ready are both 1. reqN_ready depends on valid, so a requester must
// hold valid and payload stable until it sees ready. rsp_valid is a
// single-cycle pulse with no back-pressure.
module tiny_alu_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        alu_start,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Last ISSUE cycle index; reaching it without done aborts the operation.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic        last_grant;
  logic        cur_id;
  logic [7:0]  cnt;

  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        sel_id;
  logic [2:0]  sel_op;
  logic [7:0]  sel_a;
  logic [7:0]  sel_b;
  logic        sel_noop;

  // Round-robin grant and combinational ready; reset forces ready low at once.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_grant);
    grant1     = req1_valid && (!req0_valid || !last_grant);
    req0_ready = (state == IDLE) && !reset && grant0;
    req1_ready = (state == IDLE) && !reset && grant1;
    accept     = req0_ready || req1_ready;
    sel_id     = req1_ready;
    sel_op     = sel_id ? req1_op : req0_op;
    sel_a      = sel_id ? req1_a  : req0_a;
    sel_b      = sel_id ? req1_b  : req0_b;
    // Opcode 000 and the unused codes 101..111 never reach the ALU.
    sel_noop   = (sel_op == 3'b000) || (sel_op > 3'b100);
  end

  assign dbg_state = state;

  // Control FSM with all ALU and response outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      cnt        <= 8'd0;
      alu_start  <= 1'b0;
      alu_op     <= 3'd0;
      alu_a      <= 8'd0;
      alu_b      <= 8'd0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= 16'd0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= sel_id;
            cur_id     <= sel_id;
            cnt        <= 8'd0;
            if (sel_noop) begin
              state      <= RESP;
              rsp_valid  <= 1'b1;
              rsp_id     <= sel_id;
              rsp_result <= 16'd0;
              rsp_err    <= 1'b0;
            end else begin
              state     <= ISSUE;
              alu_start <= 1'b1;
              alu_op    <= sel_op;
              alu_a     <= sel_a;
              alu_b     <= sel_b;
            end
          end
        end
        ISSUE: begin
          cnt <= cnt + 8'd1;
          if (alu_done) begin
            state      <= RESP;
            alu_start  <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_id     <= cur_id;
            rsp_result <= alu_result;
            rsp_err    <= 1'b0;
          end else if (cnt == TO_LAST) begin
            state      <= RESP;
            alu_start  <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_id     <= cur_id;
            rsp_result <= 16'd0;
            rsp_err    <= 1'b1;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_alu_arbiter.sv
// Bench for tiny_alu_arbiter: vector table plus hand-built corner sequences,
// a small ALU model with configurable latency, and a response scoreboard.
module tb_tiny_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = 3'd0, req1_op = 3'd0;
  logic [7:0]  req0_a = 8'd0, req0_b = 8'd0, req1_a = 8'd0, req1_b = 8'd0;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a, alu_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid, rsp_id, rsp_err;
  logic [15:0] rsp_result;
  logic [1:0]  dbg_state;

  tiny_alu_arbiter #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- ALU model ----------------
  // add/and/xor raise done in the 2nd start cycle, mul in the 4th.
  logic        hold_done = 1'b0;
  logic        stray_done = 1'b0;
  logic [2:0]  mcnt;

  always @(posedge clk or posedge reset) begin
    if (reset) mcnt <= 3'd0;
    else if (!alu_start) mcnt <= 3'd0;
    else if (mcnt != 3'd7) mcnt <= mcnt + 3'd1;
  end

  assign alu_done = stray_done ||
                    (alu_start && !hold_done &&
                     (mcnt == ((alu_op == 3'b100) ? 3'd3 : 3'd1)));

  always_comb begin
    alu_result = 16'd0;
    if (stray_done) alu_result = 16'hDEAD;
    else begin
      case (alu_op)
        3'b001:  alu_result = {8'd0, alu_a} + {8'd0, alu_b};
        3'b010:  alu_result = {8'd0, alu_a & alu_b};
        3'b011:  alu_result = {8'd0, alu_a ^ alu_b};
        3'b100:  alu_result = {8'd0, alu_a} * {8'd0, alu_b};
        default: alu_result = 16'd0;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  // entry = {id, err, result}
  logic [17:0] exp_q[$];
  logic        gnt_log[$];
  int          n_vec = 0;
  int          n_miss = 0;
  int          start_rises = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic        prev_start = 1'b0;
  logic        prev_rsp = 1'b0;
  logic [2:0]  prev_op = 3'd0;
  logic [7:0]  prev_a = 8'd0, prev_b = 8'd0;
  int          start_run = 0;
  int          low_run = 100;

  always @(negedge clk) begin
    if (reset) begin
      check("rsp_in_reset", {31'd0, rsp_valid}, 32'd0);
      prev_start = 1'b0;
      prev_rsp   = 1'b0;
      start_run  = 0;
      low_run    = 100;
    end else begin
      if (req0_ready || req1_ready) begin
        check("one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
        gnt_log.push_back(req1_ready);
      end
      if (alu_start && !prev_start) begin
        check("start_gap", {31'd0, low_run >= 2}, 32'd1);
        start_rises++;
        start_run = 1;
      end else if (alu_start) begin
        check("alu_hold", {13'd0, alu_op, alu_a, alu_b}, {13'd0, prev_op, prev_a, prev_b});
        start_run++;
      end else if (prev_start) begin
        check("start_len", start_run, hold_done ? 15 : ((alu_op == 3'b100) ? 4 : 2));
        check("rsp_at_end", {31'd0, rsp_valid}, 32'd1);
        low_run = 1;
      end else if (low_run < 100) begin
        low_run++;
      end
      if (rsp_valid) begin
        check("rsp_pulse", {31'd0, prev_rsp}, 32'd0);
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          check("rsp", {14'd0, rsp_id, rsp_err, rsp_result}, {14'd0, e});
        end
      end
      prev_start = alu_start;
      prev_rsp   = rsp_valid;
      prev_op    = alu_op;
      prev_a     = alu_a;
      prev_b     = alu_b;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic id, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [17:0] exp);
    bit acc = 0;
    int waited = 0;
    if (id) begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else    begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
    while (!acc && waited < 40) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        acc = 1;
        exp_q.push_back(exp);
      end
      waited++;
    end
    check("accept", {31'd0, acc}, 32'd1);
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        id;
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int rises0;
    vecs[0] = '{1'b0, 3'b001, 8'hFF, 8'h01, 16'h0100};
    vecs[1] = '{1'b1, 3'b100, 8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{1'b0, 3'b010, 8'hA5, 8'h0F, 16'h0005};
    vecs[3] = '{1'b1, 3'b011, 8'h55, 8'hAA, 16'h00FF};
    vecs[4] = '{1'b0, 3'b100, 8'h10, 8'h10, 16'h0100};
    vecs[5] = '{1'b1, 3'b001, 8'h80, 8'h7F, 16'h00FF};
    vecs[6] = '{1'b0, 3'b101, 8'h12, 8'h34, 16'h0000};
    vecs[7] = '{1'b1, 3'b100, 8'h0C, 8'h0D, 16'h009C};

    // Reset state, with a request pending to show ready is held low.
    req0_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", {alu_start, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_err},
          32'd0);
    check("reset_result", {16'd0, rsp_result}, 32'd0);
    check("reset_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Table vectors, one after another.
    for (int i = 0; i < 8; i++)
      send(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].id, 1'b0, vecs[i].res});
    drain();

    // Contention: both valid continuously, grants must alternate.
    gnt_log.delete();
    fork
      begin
        send(1'b0, 3'b011, 8'hF0, 8'h0F, {2'b00, 16'h00FF});
        send(1'b0, 3'b011, 8'hF0, 8'h0F, {2'b00, 16'h00FF});
      end
      begin
        send(1'b1, 3'b010, 8'hF0, 8'h3C, {2'b10, 16'h0030});
        send(1'b1, 3'b010, 8'hF0, 8'h3C, {2'b10, 16'h0030});
      end
    join
    drain();
    check("gnt_count", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++)
      check("gnt_order", {31'd0, gnt_log[i]}, (i % 2));

    // No_op and illegal op: response the cycle after accept, no ALU start.
    rises0 = start_rises;
    send(1'b0, 3'b000, 8'h11, 8'h22, {2'b00, 16'h0000});
    @(negedge clk);
    check("noop_rsp_next", {31'd0, rsp_valid}, 32'd1);
    drain();
    send(1'b0, 3'b111, 8'h33, 8'h44, {2'b00, 16'h0000});
    @(negedge clk);
    check("illegal_rsp_next", {31'd0, rsp_valid}, 32'd1);
    drain();
    check("noop_no_start", start_rises - rises0, 0);

    // Stray alu_done while idle is ignored.
    stray_done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stray_done_idle", {30'd0, dbg_state}, 32'd0);
    end
    stray_done = 1'b0;
    @(posedge clk); #1;

    // Timeout: done never comes; then the next request is served normally.
    hold_done = 1'b1;
    send(1'b0, 3'b001, 8'h01, 8'h02, {2'b01, 16'h0000});
    drain();
    hold_done = 1'b0;
    send(1'b1, 3'b001, 8'h03, 8'h04, {2'b10, 16'h0007});
    drain();

    // Reset in the middle of a mul issued by req0.
    send(1'b0, 3'b100, 8'h12, 8'h34, {2'b00, 16'h0000});
    @(posedge clk); #1;
    req0_op = 3'b001; req0_a = 8'h01; req0_b = 8'h01; req0_valid = 1'b1;
    check("mid_mul_start", {31'd0, alu_start}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_async_start", {31'd0, alu_start}, 32'd0);
    check("rst_async_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    check("rst_async_state", {30'd0, dbg_state}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    req0_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    gnt_log.delete();
    fork
      send(1'b0, 3'b001, 8'h01, 8'h01, {2'b00, 16'h0002});
      send(1'b1, 3'b011, 8'h0F, 8'hF0, {2'b10, 16'h00FF});
    join
    drain();
    check("post_rst_gnt_count", gnt_log.size(), 2);
    if (gnt_log.size() > 0)
      check("post_rst_first_gnt", {31'd0, gnt_log[0]}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $finish;
  end

endmodule
